// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller with a one-entry hold buffer and branch squash.
// Define FETCH_CTRL_PERF_EN to add the fetch_count / stall_count performance counters.
module fetch_ctrl #(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        pc_freeze,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  logic        blocked;
  logic        busy_done;
  logic        issue_idle;
  logic        deliver;
  logic        capture;
  logic        release_hold;
  logic [31:0] pc_seq;

  always_comb begin
    blocked      = if_valid & hazard;
    busy_done    = (state == BUSY) & imem_ready;
    issue_idle   = (state == IDLE) & ~blocked & ~branch_taken;
    deliver      = busy_done & ~blocked & ~branch_taken;
    capture      = busy_done & blocked & ~branch_taken;
    release_hold = (state == FULL) & ~hazard & ~branch_taken;
    pc_seq       = pc_q + PC_INC;
  end

  // The external PC only advances when a fetched word is consumed or on a redirect,
  // so pc_q always names the next address the controller must request.
  assign imem_req  = (state == BUSY) | (state == DROP);
  assign imem_addr = addr_q;
  assign pc_freeze = ~(branch_taken | busy_done);
  assign pc_d      = branch_taken ? branch_addr : pc_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= 32'd0;
      hold_pc    <= 32'd0;
      hold_instr <= 32'd0;
      if_valid   <= 1'b0;
      if_pc      <= 32'd0;
      if_instr   <= 32'd0;
    end else begin
      // IF/ID register: a redirect squashes, a stall holds, otherwise it drains.
      if (branch_taken) begin
        if_valid <= 1'b0;
      end else if (deliver) begin
        if_valid <= 1'b1;
        if_pc    <= addr_q;
        if_instr <= imem_rdata;
      end else if (release_hold) begin
        if_valid <= 1'b1;
        if_pc    <= hold_pc;
        if_instr <= hold_instr;
      end else if (!hazard) begin
        if_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (issue_idle) begin
            addr_q <= pc_q;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (branch_taken) begin
            state <= imem_ready ? IDLE : DROP;
          end else if (capture) begin
            hold_pc    <= addr_q;
            hold_instr <= imem_rdata;
            state      <= FULL;
          end else if (deliver) begin
            addr_q <= pc_seq;
          end
        end
        DROP: begin
          // The squashed request must still complete before a new one is issued.
          if (!branch_taken && imem_ready) begin
            state <= IDLE;
          end
        end
        FULL: begin
          if (branch_taken) begin
            hold_pc    <= 32'd0;
            hold_instr <= 32'd0;
            state      <= IDLE;
          end else if (!hazard) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (deliver | release_hold) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (imem_req & ~imem_ready) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// scored against an in-order instruction-stream model.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_freeze;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int          total = 0;
  int          bad = 0;
  logic        o_freeze;
  logic [31:0] o_pcd;

  fetch_ctrl #(.PC_INC(32'd4)) dut (
    .clk(clk),
    .rst(rst),
    .pc_q(pc_q),
    .pc_d(pc_d),
    .pc_freeze(pc_freeze),
    .hazard(hazard),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // One clock: drive inputs, capture combinational outputs, clock the external PC register.
  task automatic cycle(input logic h, input logic b, input logic [31:0] ba, input logic r);
    hazard       = h;
    branch_taken = b;
    branch_addr  = ba;
    imem_ready   = r;
    imem_rdata   = memf(imem_addr);
    #1;
    o_freeze = pc_freeze;
    o_pcd    = pc_d;
    @(posedge clk);
    #1;
    if (rst) pc_q = 32'd0;
    else if (!o_freeze) pc_q = o_pcd;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0; pc_q = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    pc_q = start;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
    total++; if (if_pc !== 32'd0) begin bad++; $display("FAIL reset_if_pc got=%h want=0", if_pc); end
    total++; if (if_instr !== 32'd0) begin bad++; $display("FAIL reset_if_instr got=%h want=0", if_instr); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req got=%b want=0", imem_req); end
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_imem_addr got=%h want=0", imem_addr); end
    total++; if (pc_freeze !== 1'b1) begin bad++; $display("FAIL reset_pc_freeze got=%b want=1", pc_freeze); end
    total++; if (pc_d !== 32'd4) begin bad++; $display("FAIL reset_pc_d got=%h want=4", pc_d); end
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%b want=1", imem_req); end
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_first_addr got=%h want=0", imem_addr); end
    $display("reset: released, first request addr=%h", imem_addr);
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp;
    do_reset(32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp = 32'(i * 4);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      total++; if (o_freeze !== 1'b0) begin bad++; $display("FAIL zw_freeze[%0d] got=%b want=0", i, o_freeze); end
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d] got=%b want=1", i, if_valid); end
      total++; if (if_pc !== exp) begin bad++; $display("FAIL zw_if_pc[%0d] got=%h want=%h", i, if_pc, exp); end
      total++; if (if_instr !== memf(exp)) begin bad++; $display("FAIL zw_instr[%0d] got=%h want=%h", i, if_instr, memf(exp)); end
      $display("zero_wait: if_pc=%h if_instr=%h", if_pc, if_instr);
    end
  endtask

  task automatic test_wait_states();
    int req_cycles;
    req_cycles = 0;
    do_reset(32'h10);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (imem_req) req_cycles++;
      total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL ws_addr[%0d] got=%h want=10", i, imem_addr); end
      cycle(1'b0, 1'b0, 32'd0, (i == 3));
      total++; if (o_freeze !== (i < 3)) begin bad++; $display("FAIL ws_freeze[%0d] got=%b want=%b", i, o_freeze, (i < 3)); end
    end
    total++; if (req_cycles != 4) begin bad++; $display("FAIL ws_req_cycles got=%0d want=4", req_cycles); end
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h10) begin bad++; $display("FAIL ws_deliver got=%b/%h want=1/10", if_valid, if_pc); end
    total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL ws_next_addr got=%h want=14", imem_addr); end
    $display("wait_states: if_pc=%h after %0d request cycles", if_pc, req_cycles);
  endtask

  task automatic test_hazard_hold();
    do_reset(32'h1C);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    total++; if (o_freeze !== 1'b0) begin bad++; $display("FAIL hz_capture_freeze got=%b want=0", o_freeze); end
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h1C) begin bad++; $display("FAIL hz_hold1 got=%b/%h want=1/1c", if_valid, if_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hz_full_req got=%b want=0", imem_req); end
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    total++; if (if_pc !== 32'h1C || if_instr !== memf(32'h1C)) begin bad++; $display("FAIL hz_hold2 got=%h want=1c", if_pc); end
    total++; if (o_freeze !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL hz_full_wait got=%b/%b want=1/0", o_freeze, imem_req); end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h20) begin bad++; $display("FAIL hz_release got=%b/%h want=1/20", if_valid, if_pc); end
    total++; if (if_instr !== memf(32'h20)) begin bad++; $display("FAIL hz_release_instr got=%h want=%h", if_instr, memf(32'h20)); end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL hz_drain got=%b want=0", if_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin bad++; $display("FAIL hz_reissue got=%b/%h want=1/24", imem_req, imem_addr); end
    $display("hazard_hold: released if_pc=20, next request addr=%h", imem_addr);
  endtask

  task automatic test_branch_drop();
    do_reset(32'h3C);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    total++; if (o_freeze !== 1'b0 || o_pcd !== 32'h100) begin bad++; $display("FAIL br_pc got=%b/%h want=0/100", o_freeze, o_pcd); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL br_squash got=%b want=0", if_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL br_drop_req got=%b/%h want=1/40", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL br_discard got=%b/%b want=0/0", if_valid, imem_req); end
    total++; if (o_freeze !== 1'b1) begin bad++; $display("FAIL br_drop_freeze got=%b want=1", o_freeze); end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL br_target_req got=%b/%h want=1/100", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin bad++; $display("FAIL br_target got=%b/%h want=1/100", if_valid, if_pc); end
    total++; if (if_instr !== memf(32'h100)) begin bad++; $display("FAIL br_target_instr got=%h want=%h", if_instr, memf(32'h100)); end
    $display("branch_drop: redirected to if_pc=%h", if_pc);
  endtask

  task automatic test_reset_mid_request();
    do_reset(32'h80);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    total++; if (imem_req !== 1'b1 || if_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b/%b want=1/1", imem_req, if_valid); end
    #2;
    rst  = 1'b1;
    pc_q = 32'd0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b want=0", imem_req); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", if_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL rm_restart got=%b/%h want=1/0", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin bad++; $display("FAIL rm_first_fetch got=%b/%h want=1/0", if_valid, if_pc); end
    $display("reset_mid_request: first fetch after release if_pc=%h", if_pc);
  endtask

`ifdef FETCH_CTRL_PERF_EN
  task automatic test_perf();
    do_reset(32'h200);
    total++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", fetch_count, stall_count); end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
    end
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL perf_fetch got=%0d want=5", fetch_count); end
    total++; if (stall_count !== 32'd10) begin bad++; $display("FAIL perf_stall got=%0d want=10", stall_count); end
    total++; if (if_pc !== 32'h210) begin bad++; $display("FAIL perf_last_pc got=%h want=210", if_pc); end
    $display("perf: fetch_count=%0d stall_count=%0d", fetch_count, stall_count);
  endtask
`endif

  // Model: accepted instructions (if_valid & !hazard) form the program-order stream
  // starting at the reset PC, stepping by 4 and restarting at each branch target.
  task automatic test_random();
    logic [31:0] exp_pc, ba, p0, i0, a0, pcq0;
    logic        h, b, r, v0, req0;
    int          idle_run, accepts;
    exp_pc = 32'd0; idle_run = 0; accepts = 0;
    do_reset(32'd0);
    for (int n = 0; n < 3000; n++) begin
      h    = ($urandom_range(0, 3) == 0);
      b    = ($urandom_range(0, 19) == 0);
      ba   = 32'($urandom_range(0, 1023) * 4);
      r    = imem_req && ($urandom_range(0, 2) != 0);
      v0   = if_valid; p0 = if_pc; i0 = if_instr;
      req0 = imem_req; a0 = imem_addr; pcq0 = pc_q;
      if (v0 && !h) begin
        total++; if (p0 !== exp_pc) begin bad++; $display("FAIL rnd_pc got=%h want=%h", p0, exp_pc); end
        total++; if (i0 !== memf(exp_pc)) begin bad++; $display("FAIL rnd_instr got=%h want=%h", i0, memf(exp_pc)); end
        $display("fetch: pc=%h instr=%h", p0, i0);
        exp_pc = exp_pc + 32'd4;
        accepts++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (b) exp_pc = ba;
      cycle(h, b, ba, r);
      total++; if (o_pcd !== (b ? ba : pcq0 + 32'd4)) begin bad++; $display("FAIL rnd_pc_d got=%h want=%h", o_pcd, (b ? ba : pcq0 + 32'd4)); end
      if (b) begin
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rnd_branch_squash got=%b want=0", if_valid); end
      end else if (v0 && h) begin
        total++; if (if_valid !== 1'b1 || if_pc !== p0 || if_instr !== i0) begin bad++; $display("FAIL rnd_stall_hold got=%b/%h want=1/%h", if_valid, if_pc, p0); end
      end
      if (req0 && !r) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== a0) begin bad++; $display("FAIL rnd_addr_stable got=%b/%h want=1/%h", imem_req, imem_addr, a0); end
      end
      if (idle_run > 100) begin
        total++; bad++;
        $display("FAIL rnd_progress got=%0d idle cycles want<=100", idle_run);
        break;
      end
    end
    total++; if (accepts < 300) begin bad++; $display("FAIL rnd_throughput got=%0d want>=300", accepts); end
    $display("random: %0d instructions accepted", accepts);
  endtask

  initial begin
    rst = 1'b1; pc_q = 32'd0; hazard = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hazard_hold();
    test_branch_drop();
    test_reset_mid_request();
`ifdef FETCH_CTRL_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
